// File: rtl/kyber_pkg.sv
// Shared constants and types for the Kyber inverse-NTT sequencing logic.
package kyber_pkg;

   localparam int KYBER_N      = 256;
   localparam int NUM_LAYERS   = 7;
   localparam int ZETA_START   = 127;
   localparam int ADDR_W       = 8;
   localparam int COEF_W       = 16;
   localparam int ZETA_W       = 7;
   localparam int LAYER_W      = 3;
   localparam int BF_PER_LAYER = KYBER_N / 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } state_t;

endpackage

// File: rtl/invntt_addr_gen.sv
// Butterfly address / zeta index generator for the Gentleman-Sande inverse NTT.
// Outputs are registered on each advance and hold their value otherwise.
module invntt_addr_gen
   import kyber_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              adv,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   output logic [ZETA_W-1:0] zeta_idx,
   output logic              layer_end,
   output logic              all_done
);

   logic [LAYER_W-1:0] layer;
   logic [ZETA_W-1:0]  bf;
   logic [ZETA_W-1:0]  zeta_cnt;
   logic [3:0]         sh;
   logic [ADDR_W-1:0]  len;
   logic [ADDR_W-1:0]  bf8;
   logic [ADDR_W-1:0]  j;
   logic               grp_end;

   // j = group * 2*len + offset within group; len = 2^(layer+1)
   always_comb begin
      sh        = {1'b0, layer} + 4'd1;
      len       = ADDR_W'(1) << sh;
      bf8       = {1'b0, bf};
      j         = ((bf8 >> sh) << (sh + 4'd1)) | (bf8 & (len - ADDR_W'(1)));
      grp_end   = (bf8 & (len - ADDR_W'(1))) == (len - ADDR_W'(1));
      layer_end = (bf == ZETA_W'(BF_PER_LAYER - 1));
      all_done  = (layer == LAYER_W'(NUM_LAYERS));
   end

   // Butterfly / layer / zeta counters and registered issue outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         layer     <= '0;
         bf        <= '0;
         zeta_cnt  <= ZETA_W'(ZETA_START);
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         zeta_idx  <= '0;
      end else if (clear) begin
         layer    <= '0;
         bf       <= '0;
         zeta_cnt <= ZETA_W'(ZETA_START);
      end else if (adv) begin
         rd_addr_a <= j;
         rd_addr_b <= j + len;
         zeta_idx  <= zeta_cnt;
         bf        <= bf + ZETA_W'(1);
         if (layer_end)
            layer <= layer + LAYER_W'(1);
         // zeta steps down once per group; the count runs across layers
         if (grp_end)
            zeta_cnt <= zeta_cnt - ZETA_W'(1);
      end
   end

endmodule

// File: rtl/invntt_ctrl.sv
// Inverse NTT sequencer: walks 7 layers of 128 butterflies over the coefficient
// RAM, feeds an external butterfly unit and writes its results back.
//
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | issuing one butterfly per cycle (128 per layer)
//   DRAIN  | no issue; lets the layer's writes land before the next layer reads
//   FINISH | one-cycle done pulse
module invntt_ctrl
   import kyber_pkg::*;
#(
   parameter int BF_LAT  = 2,
   parameter int RAM_LAT = 1
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [ADDR_W-1:0]        rd_addr_a,
   output logic [ADDR_W-1:0]        rd_addr_b,
   input  logic signed [COEF_W-1:0] rd_data_a,
   input  logic signed [COEF_W-1:0] rd_data_b,
   output logic [ZETA_W-1:0]        zeta_idx,
   input  logic signed [COEF_W-1:0] zeta_data,
   output logic                     bf_set,
   output logic signed [COEF_W-1:0] bf_f1,
   output logic signed [COEF_W-1:0] bf_f2,
   output logic signed [COEF_W-1:0] bf_zeta,
   input  logic signed [COEF_W-1:0] bf_r1,
   input  logic signed [COEF_W-1:0] bf_r2,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr_a,
   output logic [ADDR_W-1:0]        wr_addr_b,
   output logic signed [COEF_W-1:0] wr_data_a,
   output logic signed [COEF_W-1:0] wr_data_b
);

   localparam int PIPE_LEN  = RAM_LAT + BF_LAT;
   localparam int DRAIN_CYC = PIPE_LEN + 1;

   state_t              state;
   state_t              state_n;
   logic                adv;
   logic                clear;
   logic                layer_end;
   logic                all_done;
   logic                iss_vld;
   logic [7:0]          drain_cnt;
   logic [PIPE_LEN-1:0] vld_sr;
   logic [ADDR_W-1:0]   addr_a_sr [PIPE_LEN];
   logic [ADDR_W-1:0]   addr_b_sr [PIPE_LEN];

   invntt_addr_gen u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .adv       (adv),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .zeta_idx  (zeta_idx),
      .layer_end (layer_end),
      .all_done  (all_done)
   );

   // State register and drain down-counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         drain_cnt <= '0;
      end else begin
         state <= state_n;
         if (state == RUN && layer_end)
            drain_cnt <= 8'(DRAIN_CYC - 1);
         else if (state == DRAIN && drain_cnt != '0)
            drain_cnt <= drain_cnt - 8'd1;
      end
   end

   // Next-state and counter strobes
   always_comb begin
      state_n = state;
      adv     = 1'b0;
      clear   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clear   = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            adv = 1'b1;
            if (layer_end)
               state_n = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt == '0)
               state_n = all_done ? FINISH : RUN;
         end
         FINISH:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Issue-valid and write-address delay line (stage k = issue delayed k+1)
   always_ff @(posedge clk) begin
      if (rst) begin
         iss_vld <= 1'b0;
         vld_sr  <= '0;
         for (int i = 0; i < PIPE_LEN; i++) begin
            addr_a_sr[i] <= '0;
            addr_b_sr[i] <= '0;
         end
      end else begin
         iss_vld      <= adv;
         vld_sr       <= {vld_sr[PIPE_LEN-2:0], iss_vld};
         addr_a_sr[0] <= rd_addr_a;
         addr_b_sr[0] <= rd_addr_b;
         for (int i = 1; i < PIPE_LEN; i++) begin
            addr_a_sr[i] <= addr_a_sr[i-1];
            addr_b_sr[i] <= addr_b_sr[i-1];
         end
      end
   end

   // Status, butterfly operands and write port; data is zeroed when not valid
   always_comb begin
      busy      = (state == RUN) || (state == DRAIN);
      done      = (state == FINISH);
      bf_set    = vld_sr[RAM_LAT-1];
      bf_f1     = bf_set ? rd_data_a : '0;
      bf_f2     = bf_set ? rd_data_b : '0;
      bf_zeta   = bf_set ? zeta_data : '0;
      wr_en     = vld_sr[PIPE_LEN-1];
      wr_addr_a = addr_a_sr[PIPE_LEN-1];
      wr_addr_b = addr_b_sr[PIPE_LEN-1];
      wr_data_a = wr_en ? bf_r1 : '0;
      wr_data_b = wr_en ? bf_r2 : '0;
   end

endmodule

// File: tb/tb_invntt_ctrl.sv
// Bench for invntt_ctrl: two instances (BF_LAT=2 and 3) against RAM/ROM and
// butterfly models, with a golden inverse NTT feeding a write scoreboard.
module tb_invntt_ctrl;
   import kyber_pkg::*;

   localparam int Q = 3329;

   typedef struct {
      int a;
      int b;
      int da;
      int db;
   } wr_t;

   logic clk, rst, start, preload;
   logic busy [2], done [2], bf_set [2], wr_en [2];
   logic [7:0] rd_addr_a [2], rd_addr_b [2], wr_addr_a [2], wr_addr_b [2];
   logic [6:0] zeta_idx [2];
   logic signed [15:0] bf_f1 [2], bf_f2 [2], bf_zeta [2], wr_data_a [2], wr_data_b [2];
   logic signed [15:0] zetas [128];

   int errors = 0;
   int checks = 0;
   wr_t exp_q0 [$];
   wr_t exp_q1 [$];
   int wcnt [2][256];
   int gold [256];

   function automatic int bf_add(input int a, input int b);
      int s;
      s = (a + b) % Q;
      if (s < 0) s += Q;
      return s;
   endfunction

   function automatic int bf_mul(input int a, input int b, input int z);
      int p;
      p = (z * (b - a)) % Q;
      if (p < 0) p += Q;
      return p;
   endfunction

   function automatic int brv7(input int x);
      int r;
      r = 0;
      for (int i = 0; i < 7; i++) r |= ((x >> i) & 1) << (6 - i);
      return r;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int BL = 2 + g;
      logic signed [15:0] mem [256];
      logic signed [15:0] p1 [BL];
      logic signed [15:0] p2 [BL];
      logic signed [15:0] rd_a, rd_b, zd;

      invntt_ctrl #(.BF_LAT(BL), .RAM_LAT(1)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .start     (start),
         .busy      (busy[g]),
         .done      (done[g]),
         .rd_addr_a (rd_addr_a[g]),
         .rd_addr_b (rd_addr_b[g]),
         .rd_data_a (rd_a),
         .rd_data_b (rd_b),
         .zeta_idx  (zeta_idx[g]),
         .zeta_data (zd),
         .bf_set    (bf_set[g]),
         .bf_f1     (bf_f1[g]),
         .bf_f2     (bf_f2[g]),
         .bf_zeta   (bf_zeta[g]),
         .bf_r1     (p1[BL-1]),
         .bf_r2     (p2[BL-1]),
         .wr_en     (wr_en[g]),
         .wr_addr_a (wr_addr_a[g]),
         .wr_addr_b (wr_addr_b[g]),
         .wr_data_a (wr_data_a[g]),
         .wr_data_b (wr_data_b[g])
      );

      // RAM, zeta ROM (1-cycle read) and BL-stage butterfly model
      always @(posedge clk) begin
         if (preload) begin
            for (int a = 0; a < 256; a++) mem[a] <= 16'(a);
         end else if (wr_en[g]) begin
            mem[wr_addr_a[g]] <= wr_data_a[g];
            mem[wr_addr_b[g]] <= wr_data_b[g];
         end
         rd_a  <= mem[rd_addr_a[g]];
         rd_b  <= mem[rd_addr_b[g]];
         zd    <= zetas[zeta_idx[g]];
         p1[0] <= 16'(bf_add(int'(bf_f1[g]), int'(bf_f2[g])));
         p2[0] <= 16'(bf_mul(int'(bf_f1[g]), int'(bf_f2[g]), int'(bf_zeta[g])));
         for (int s = 1; s < BL; s++) begin
            p1[s] <= p1[s-1];
            p2[s] <= p2[s-1];
         end
      end
   end

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; preload = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (busy[i] !== 1'b0 || done[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_status inst%0d busy=%0b done=%0b required 0 0", i, busy[i], done[i]);
         end
         checks++;
         if (wr_en[i] !== 1'b0 || bf_set[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes inst%0d wr_en=%0b bf_set=%0b required 0 0", i, wr_en[i], bf_set[i]);
         end
         checks++;
         if ({rd_addr_a[i], rd_addr_b[i], zeta_idx[i], wr_addr_a[i], wr_addr_b[i]} !== 39'd0) begin
            errors++;
            $display("FAIL reset_addr inst%0d rd=%0d,%0d z=%0d wr=%0d,%0d required all 0", i,
                     rd_addr_a[i], rd_addr_b[i], zeta_idx[i], wr_addr_a[i], wr_addr_b[i]);
         end
         checks++;
         if ({bf_f1[i], bf_f2[i], bf_zeta[i], wr_data_a[i], wr_data_b[i]} !== 80'd0) begin
            errors++;
            $display("FAIL reset_data inst%0d f1=%0d f2=%0d z=%0d wd=%0d,%0d required all 0", i,
                     bf_f1[i], bf_f2[i], bf_zeta[i], wr_data_a[i], wr_data_b[i]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_run(input int extra_start);
      int k, len, t, u, lay, ea, eb, ez, bad0, bad1;
      bit chk, empty;
      wr_t e;
      int issue_n [2], wr_n [2], done_cyc [2], done_cnt [2], snap_a [2], snap_b [2];
      logic [7:0] pra [2], prb [2];
      logic [6:0] pz [2];

      for (int a = 0; a < 256; a++) gold[a] = a;
      exp_q0.delete();
      exp_q1.delete();
      k = ZETA_START;
      for (int l = 0; l < NUM_LAYERS; l++) begin
         len = 2 << l;
         for (int st = 0; st < 256; st += 2 * len) begin
            for (int j = st; j < st + len; j++) begin
               t = gold[j];
               u = gold[j+len];
               gold[j]     = bf_add(t, u);
               gold[j+len] = bf_mul(t, u, int'(zetas[k]));
               e.a = j; e.b = j + len; e.da = gold[j]; e.db = gold[j+len];
               exp_q0.push_back(e);
               exp_q1.push_back(e);
            end
            k--;
         end
      end
      for (int i = 0; i < 2; i++) begin
         issue_n[i] = 0; wr_n[i] = 0; done_cyc[i] = -1; done_cnt[i] = 0;
         snap_a[i] = 0; snap_b[i] = 0; pra[i] = '0; prb[i] = '0; pz[i] = '0;
         for (int a = 0; a < 256; a++) wcnt[i][a] = 0;
      end

      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
      start = 1'b1;
      for (int cyc = 1; cyc <= 1000; cyc++) begin
         @(negedge clk);
         start = (cyc == extra_start);
         for (int i = 0; i < 2; i++) begin
            if (cyc == 1) begin
               checks++;
               if (busy[i] !== 1'b1) begin
                  errors++;
                  $display("FAIL busy_after_start inst%0d busy=%0b required 1", i, busy[i]);
               end
            end
            if (bf_set[i]) begin
               lay = issue_n[i] / BF_PER_LAYER;
               checks++;
               if (pz[i] == 7'd0) begin
                  errors++;
                  $display("FAIL zeta_nonzero inst%0d issue=%0d zeta_idx=0 required >=1", i, issue_n[i]);
               end
               checks++;
               if (snap_a[i] != lay || snap_b[i] != lay) begin
                  errors++;
                  $display("FAIL read_after_write inst%0d issue=%0d addr=%0d,%0d writes=%0d,%0d required %0d",
                           i, issue_n[i], pra[i], prb[i], snap_a[i], snap_b[i], lay);
               end
               chk = 1'b1;
               case (issue_n[i])
                  0:       begin ea = 0;   eb = 2;   ez = 127; end
                  1:       begin ea = 1;   eb = 3;   ez = 127; end
                  2:       begin ea = 4;   eb = 6;   ez = 126; end
                  768:     begin ea = 0;   eb = 128; ez = 1;   end
                  895:     begin ea = 127; eb = 255; ez = 1;   end
                  default: begin ea = 0;   eb = 0;   ez = 0;   chk = 1'b0; end
               endcase
               if (chk) begin
                  checks++;
                  if (pra[i] !== 8'(ea) || prb[i] !== 8'(eb) || pz[i] !== 7'(ez)) begin
                     errors++;
                     $display("FAIL issue_tuple inst%0d issue=%0d got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                              i, issue_n[i], pra[i], prb[i], pz[i], ea, eb, ez);
                  end
               end
               issue_n[i]++;
            end
            snap_a[i] = wcnt[i][rd_addr_a[i]];
            snap_b[i] = wcnt[i][rd_addr_b[i]];
            pra[i] = rd_addr_a[i];
            prb[i] = rd_addr_b[i];
            pz[i]  = zeta_idx[i];
            if (wr_en[i]) begin
               checks++;
               empty = (i == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
               if (empty) begin
                  errors++;
                  $display("FAIL write_extra inst%0d addr=%0d,%0d required no write", i, wr_addr_a[i], wr_addr_b[i]);
               end else begin
                  e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                  if (wr_addr_a[i] !== 8'(e.a) || wr_addr_b[i] !== 8'(e.b) ||
                      wr_data_a[i] !== 16'(e.da) || wr_data_b[i] !== 16'(e.db)) begin
                     errors++;
                     $display("FAIL write_data inst%0d #%0d got [%0d]=%0d [%0d]=%0d required [%0d]=%0d [%0d]=%0d",
                              i, wr_n[i], wr_addr_a[i], wr_data_a[i], wr_addr_b[i], wr_data_b[i],
                              e.a, e.da, e.b, e.db);
                  end
               end
               wcnt[i][wr_addr_a[i]]++;
               wcnt[i][wr_addr_b[i]]++;
               wr_n[i]++;
            end
            if (done[i]) begin
               done_cnt[i]++;
               if (done_cyc[i] < 0) done_cyc[i] = cyc;
               checks++;
               if (busy[i] !== 1'b0) begin
                  errors++;
                  $display("FAIL busy_at_done inst%0d busy=%0b required 0", i, busy[i]);
               end
            end
         end
      end
      start = 1'b0;

      for (int i = 0; i < 2; i++) begin
         checks++;
         if (done_cnt[i] != 1 || done_cyc[i] != 7 * (128 + 1 + (2 + i) + 1) + 1) begin
            errors++;
            $display("FAIL done_timing inst%0d pulses=%0d cycle=%0d required 1 at %0d",
                     i, done_cnt[i], done_cyc[i], 7 * (128 + 1 + (2 + i) + 1) + 1);
         end
         checks++;
         if (wr_n[i] != 896) begin
            errors++;
            $display("FAIL write_count inst%0d got=%0d required 896", i, wr_n[i]);
         end
         checks++;
         if (busy[i] !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_run inst%0d busy=%0b required 0", i, busy[i]);
         end
      end
      bad0 = 0;
      bad1 = 0;
      for (int a = 0; a < 256; a++) begin
         if (g_inst[0].mem[a] !== 16'(gold[a])) bad0++;
         if (g_inst[1].mem[a] !== 16'(gold[a])) bad1++;
      end
      checks++;
      if (bad0 != 0) begin
         errors++;
         $display("FAIL ram_golden inst0 wrong_words=%0d required 0", bad0);
      end
      checks++;
      if (bad1 != 0) begin
         errors++;
         $display("FAIL ram_golden inst1 wrong_words=%0d required 0", bad1);
      end
   endtask

   task automatic test_abort;
      int bad_wr, bad_busy;
      start = 1'b1;
      for (int cyc = 1; cyc <= 300; cyc++) begin
         @(negedge clk);
         start = 1'b0;
      end
      checks++;
      if (busy[0] !== 1'b1 || busy[1] !== 1'b1) begin
         errors++;
         $display("FAIL busy_before_abort busy=%0b,%0b required 1,1", busy[0], busy[1]);
      end
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      bad_wr = 0;
      bad_busy = 0;
      for (int c = 0; c < 200; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (wr_en[i] !== 1'b0) bad_wr++;
            if (busy[i] !== 1'b0) bad_busy++;
         end
         @(negedge clk);
      end
      checks++;
      if (bad_wr != 0) begin
         errors++;
         $display("FAIL abort_no_write wr_en_cycles=%0d required 0", bad_wr);
      end
      checks++;
      if (bad_busy != 0) begin
         errors++;
         $display("FAIL abort_idle busy_cycles=%0d required 0", bad_busy);
      end
   endtask

   initial begin
      int v;
      for (int k = 0; k < 128; k++) begin
         v = 1;
         for (int e = 0; e < brv7(k); e++) v = (v * 17) % Q;
         zetas[k] = 16'(v);
      end
      rst = 1'b1;
      start = 1'b0;
      preload = 1'b0;
      test_reset();
      test_full_run(200);
      test_abort();
      test_full_run(130);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/invntt_ctrl.md
INVNTT_CTRL -- requirements
Module: invntt_ctrl

Interface
REQ-001 The block SHALL have parameter BF_LAT, default 2, the invntt_cal butterfly latency in cycles from bf_set/operands to bf_r1/bf_r2.
REQ-002 The block SHALL have parameter RAM_LAT, fixed 1, the coefficient RAM and zeta ROM read latency.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse; begins inverse NTT of the 256-coefficient RAM.
REQ-006 busy  out  1  high from the cycle after an accepted start until done.
REQ-007 done  out  1  one-cycle pulse at completion.
REQ-008 rd_addr_a, rd_addr_b  out  8 each  RAM read addresses (j, j+len).
REQ-009 rd_data_a, rd_data_b  in  16 signed each  RAM read data, valid RAM_LAT after the address.
REQ-010 zeta_idx  out  7  zeta ROM index; zeta_data  in  16 signed, valid RAM_LAT after the index.
REQ-011 bf_set  out  1; bf_f1, bf_f2, bf_zeta  out  16 signed each  butterfly operands.
REQ-012 bf_r1, bf_r2  in  16 signed each  butterfly results.
REQ-013 wr_en  out  1; wr_addr_a, wr_addr_b  out  8 each; wr_data_a, wr_data_b  out  16 signed each  RAM write port.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN, FINISH; start is accepted only in IDLE; start outside IDLE SHALL be ignored.
REQ-015 Seven layers l=0..6 with len=2^(l+1); each layer SHALL issue 128 butterflies b=0..127, one per cycle in RUN, no bubbles.
REQ-016 Butterfly b in layer l SHALL use j = ((b>>(l+1))<<(l+2)) | (b & (len-1)); rd_addr_a=j, rd_addr_b=j+len.
REQ-017 zeta_idx SHALL start at 127 and decrement by 1 at each group boundary (every len butterflies), across layers; last value is 1 (127 groups total).
REQ-018 bf_f1=rd_data_a, bf_f2=rd_data_b, bf_zeta=zeta_data, bf_set=1, all in the cycle RAM_LAT after issue; bf_set SHALL be 0 otherwise.
REQ-019 Issued addresses SHALL be delayed RAM_LAT+BF_LAT cycles; wr_en SHALL pulse in that cycle with wr_data_a=bf_r1, wr_data_b=bf_r2 and the delayed addresses.
REQ-020 After the 128th issue of a layer, FSM SHALL enter DRAIN for RAM_LAT+BF_LAT+1 cycles, issuing nothing, so all layer-l writes commit before any layer-l+1 read.
REQ-021 After DRAIN of layer 6, FSM SHALL enter FINISH for one cycle: done=1, busy=0, then IDLE.
REQ-022 Start-to-done latency SHALL be 7*(128+RAM_LAT+BF_LAT+1)+1 cycles (925 at defaults).
REQ-023 Final multiplication by f=1441 is out of scope (downstream stage).
REQ-024 Address/zeta outputs SHALL hold last value when not issuing; only wr_en and bf_set qualify validity.

Reset
REQ-025 rst SHALL force IDLE, busy=0, done=0, wr_en=0, bf_set=0, all addresses/zeta_idx/data outputs 0, delay pipeline valids cleared, in the next cycle.
REQ-026 rst mid-operation SHALL abort: no wr_en after reset; rst wins over simultaneous start.

Structure
REQ-027 Package kyber_pkg SHALL hold KYBER_N=256, NUM_LAYERS=7, ZETA_START=127, address width 8, coefficient width 16, FSM state typedef.
REQ-028 Address and zeta counter logic SHALL be sub-module invntt_addr_gen; delay pipeline and FSM stay in invntt_ctrl; invntt_cal is instantiated by the parent, not inside.

Verification
REQ-029 Reset: assert rst 2 cycles -> all outputs 0, busy 0.
REQ-030 Start pulse -> issue cycles 1..3 give (rd_addr_a,rd_addr_b,zeta_idx) = (0,2,127),(1,3,127),(4,6,126).
REQ-031 Layer 6 first issue -> (0,128,1); last issue -> (127,255,1); zeta_idx never 0.
REQ-032 Full run, RAM preload r[i]=i, behavioural butterfly (BF_LAT=2) -> RAM matches golden invNTT without scaling; done single pulse at cycle 925; exactly 896 wr_en pulses.
REQ-033 BF_LAT=3 run -> scoreboard confirms no layer-l+1 read of an address before its layer-l write; result identical to golden.
REQ-034 start during busy ignored; rst at cycle 300 -> no wr_en afterwards, busy 0; new start then completes correctly.
